// File: rtl/tex_addr_sched_if.sv
// Bundle of requester, address-unit and response signals around tex_addr_sched.
// slave = the scheduler; master = requesters plus address unit.
interface tex_addr_sched_if #(
    parameter int NUM_REQS    = 4,
    parameter int REQ_DATAW   = 256,
    parameter int RSP_DATAW   = 512,
    parameter int REQ_INFOW   = 8,
    parameter int MAX_PENDING = 4
);
    localparam int SEL_BITS = $clog2(NUM_REQS);
    localparam int TAG_W    = REQ_INFOW + SEL_BITS;
    localparam int CNT_W    = $clog2(MAX_PENDING + 1);

    logic [NUM_REQS-1:0]           req_valid;
    logic [NUM_REQS*REQ_DATAW-1:0] req_data;
    logic [NUM_REQS*REQ_INFOW-1:0] req_info;
    logic [NUM_REQS-1:0]           req_ready;

    logic                          addr_req_valid;
    logic [REQ_DATAW-1:0]          addr_req_data;
    logic [TAG_W-1:0]              addr_req_info;
    logic                          addr_req_ready;

    logic                          addr_rsp_valid;
    logic [RSP_DATAW-1:0]          addr_rsp_data;
    logic [TAG_W-1:0]              addr_rsp_info;
    logic                          addr_rsp_ready;

    logic [NUM_REQS-1:0]           rsp_valid;
    logic [RSP_DATAW-1:0]          rsp_data;
    logic [REQ_INFOW-1:0]          rsp_info;
    logic [NUM_REQS-1:0]           rsp_ready;

    logic [CNT_W-1:0]              pending_count;

    modport slave (
        input  req_valid, req_data, req_info,
        output req_ready,
        output addr_req_valid, addr_req_data, addr_req_info,
        input  addr_req_ready,
        input  addr_rsp_valid, addr_rsp_data, addr_rsp_info,
        output addr_rsp_ready,
        output rsp_valid, rsp_data, rsp_info,
        input  rsp_ready,
        output pending_count
    );

    modport master (
        output req_valid, req_data, req_info,
        input  req_ready,
        input  addr_req_valid, addr_req_data, addr_req_info,
        output addr_req_ready,
        output addr_rsp_valid, addr_rsp_data, addr_rsp_info,
        input  addr_rsp_ready,
        input  rsp_valid, rsp_data, rsp_info,
        output rsp_ready,
        input  pending_count
    );
endinterface

// File: rtl/tex_addr_sched.sv
// Round-robin arbiter sharing one texture address unit, with credit-bounded in-flight requests.
// Optional stall counters are built when TEX_SCHED_PERF_EN is defined.
module tex_addr_sched #(
    parameter int NUM_REQS    = 4,
    parameter int REQ_DATAW   = 256,
    parameter int RSP_DATAW   = 512,
    parameter int REQ_INFOW   = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    tex_addr_sched_if.slave   bus
`ifdef TEX_SCHED_PERF_EN
    ,
    output logic [43:0]       perf_stall_credit,
    output logic [43:0]       perf_stall_slot
`endif
);
    localparam int SEL_BITS = $clog2(NUM_REQS);
    localparam int TAG_W    = REQ_INFOW + SEL_BITS;
    localparam int CNT_W    = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    typedef logic [SEL_BITS-1:0] sel_t;

    sel_t                 rr_ptr;
    sel_t                 ptr_next;
    sel_t                 win_idx;
    sel_t                 cand;
    sel_t                 rsp_sel;
    logic                 win_found;
    logic                 slot_valid;
    logic                 slot_free;
    logic                 credit_ok;
    logic                 grant_int;
    logic                 rsp_fire;
    logic [REQ_DATAW-1:0] slot_data;
    logic [TAG_W-1:0]     slot_info;
    logic [CNT_W-1:0]     pend_q;

    function automatic sel_t wrap_add(sel_t base, int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQS) s = s - NUM_REQS;
        return sel_t'(s);
    endfunction

    // Scan upward from the round-robin pointer; first valid requester wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign slot_free = ~slot_valid | bus.addr_req_ready;
    assign credit_ok = pend_q < CNT_MAX;
    assign grant_int = slot_free & credit_ok & win_found;
    assign ptr_next  = (win_idx == sel_t'(NUM_REQS - 1)) ? '0 : win_idx + sel_t'(1);

    // Flops are held by the async reset; only the visible handshake needs masking.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++)
            bus.req_ready[i] = grant_int && !reset && (win_idx == sel_t'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= 1'b0;
            rr_ptr     <= '0;
        end else if (grant_int) begin
            slot_valid <= 1'b1;
            rr_ptr     <= ptr_next;
        end else if (bus.addr_req_ready) begin
            slot_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_int) begin
            slot_data <= bus.req_data[int'(win_idx)*REQ_DATAW +: REQ_DATAW];
            slot_info <= {bus.req_info[int'(win_idx)*REQ_INFOW +: REQ_INFOW], win_idx};
        end
    end

    assign bus.addr_req_valid = slot_valid;
    assign bus.addr_req_data  = slot_data;
    assign bus.addr_req_info  = slot_info;

    assign rsp_sel  = bus.addr_rsp_info[SEL_BITS-1:0];
    assign rsp_fire = bus.addr_rsp_valid & bus.addr_rsp_ready;

    always_comb begin
        bus.rsp_valid      = '0;
        bus.addr_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_sel == sel_t'(i)) begin
                bus.rsp_valid[i]   = bus.addr_rsp_valid;
                bus.addr_rsp_ready = bus.rsp_ready[i];
            end
        end
    end

    assign bus.rsp_info = bus.addr_rsp_info[TAG_W-1:SEL_BITS];
    assign bus.rsp_data = bus.addr_rsp_data;

    // Grant and delivery in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else if (grant_int && !rsp_fire) begin
            pend_q <= pend_q + CNT_W'(1);
        end else if (!grant_int && rsp_fire && pend_q != '0) begin
            pend_q <= pend_q - CNT_W'(1);
        end
    end

    assign bus.pending_count = pend_q;

`ifdef TEX_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_credit <= '0;
            perf_stall_slot   <= '0;
        end else begin
            if (win_found && slot_free && pend_q == CNT_MAX && !(&perf_stall_credit))
                perf_stall_credit <= perf_stall_credit + 44'd1;
            if (win_found && !slot_free && !(&perf_stall_slot))
                perf_stall_slot <= perf_stall_slot + 44'd1;
        end
    end
`endif

    a_rsp_needs_credit: assert property (@(posedge clk) disable iff (reset)
        bus.addr_rsp_valid |-> pend_q != '0);
    a_rsp_sel_range: assert property (@(posedge clk) disable iff (reset)
        bus.addr_rsp_valid |-> int'(rsp_sel) < NUM_REQS);
    a_pend_bound: assert property (@(posedge clk) disable iff (reset)
        pend_q <= CNT_MAX);
endmodule

// File: tb/tb_tex_addr_sched.sv
// Bench for tex_addr_sched: directed scenarios plus random traffic against a
// transaction-level model (round-robin pick, credit count, address-unit queue).
module tb_tex_addr_sched;
    localparam int NUM_REQS    = 4;
    localparam int REQ_DATAW   = 256;
    localparam int RSP_DATAW   = 512;
    localparam int REQ_INFOW   = 8;
    localparam int MAX_PENDING = 4;
    localparam int SEL_BITS    = 2;
    localparam int TAG_W       = REQ_INFOW + SEL_BITS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tex_addr_sched_if #(
        .NUM_REQS(NUM_REQS), .REQ_DATAW(REQ_DATAW), .RSP_DATAW(RSP_DATAW),
        .REQ_INFOW(REQ_INFOW), .MAX_PENDING(MAX_PENDING)
    ) bus ();

`ifdef TEX_SCHED_PERF_EN
    logic [43:0] perf_stall_credit;
    logic [43:0] perf_stall_slot;
`endif

    tex_addr_sched #(
        .NUM_REQS(NUM_REQS), .REQ_DATAW(REQ_DATAW), .RSP_DATAW(RSP_DATAW),
        .REQ_INFOW(REQ_INFOW), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef TEX_SCHED_PERF_EN
        , .perf_stall_credit(perf_stall_credit)
        , .perf_stall_slot(perf_stall_slot)
`endif
    );

    typedef struct {
        logic [TAG_W-1:0]     tag;
        logic [REQ_DATAW-1:0] d;
        int                   due;
    } au_t;

    au_t au_q[$];
    int  obs_grants[$];
    int  obs_tags[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [NUM_REQS-1:0] en_mask = '0;
    int p_valid = 100, p_aready = 100, p_rready = 100;
    int rready_force = -1, rsp_budget = -1, rsp_lat = 0;

    int                   m_ptr, m_cnt, m_win, last_win;
    bit                   m_slot_v, m_grant, m_deliver;
    logic [REQ_DATAW-1:0] m_slot_d;
    logic [TAG_W-1:0]     m_slot_t;
    logic [SEL_BITS-1:0]  m_sel;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_cnt    = 0;
        m_slot_v = 1'b0;
        au_q.delete();
    endtask

    task automatic idle_inputs();
        bus.req_valid      = '0;
        bus.addr_rsp_valid = 1'b0;
    endtask

    function automatic int obs_winner();
        for (int i = 0; i < NUM_REQS; i++)
            if (bus.req_ready[i]) return i;
        return -1;
    endfunction

    // Drive inputs on the falling edge, then compare every output with the model.
    task automatic cycle_begin();
        int exp_rdy;
        int exp_rv;
        @(negedge clk);
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.req_valid[i] = en_mask[i] && ($urandom_range(0, 99) < p_valid);
            for (int w = 0; w < REQ_DATAW / 32; w++)
                bus.req_data[i*REQ_DATAW + w*32 +: 32] = $urandom();
            bus.req_info[i*REQ_INFOW +: REQ_INFOW] = REQ_INFOW'($urandom());
            bus.rsp_ready[i] = (rready_force >= 0) ? rready_force[i]
                                                    : ($urandom_range(0, 99) < p_rready);
        end
        bus.addr_req_ready = $urandom_range(0, 99) < p_aready;
        if (rsp_budget != 0 && au_q.size() > 0 && au_q[0].due <= cyc) begin
            bus.addr_rsp_valid = 1'b1;
            bus.addr_rsp_info  = au_q[0].tag;
            bus.addr_rsp_data  = {~au_q[0].d, au_q[0].d};
        end else begin
            bus.addr_rsp_valid = 1'b0;
            bus.addr_rsp_info  = TAG_W'($urandom());
            bus.addr_rsp_data  = {16{$urandom()}};
        end
        #1;
        m_grant = (!m_slot_v || bus.addr_req_ready) && (m_cnt < MAX_PENDING) && (|bus.req_valid);
        m_win = -1;
        for (int k = 0; k < NUM_REQS; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQS;
            if (m_win < 0 && bus.req_valid[idx]) m_win = idx;
        end
        exp_rdy = m_grant ? (1 << m_win) : 0;
        check("req_ready", 512'(bus.req_ready), 512'(exp_rdy));
        check("addr_req_valid", 512'(bus.addr_req_valid), 512'(m_slot_v));
        if (m_slot_v) begin
            check("addr_req_data", 512'(bus.addr_req_data), 512'(m_slot_d));
            check("addr_req_info", 512'(bus.addr_req_info), 512'(m_slot_t));
        end
        check("pending_count", 512'(bus.pending_count), 512'(m_cnt));
        m_sel  = bus.addr_rsp_info[SEL_BITS-1:0];
        exp_rv = bus.addr_rsp_valid ? (1 << m_sel) : 0;
        check("rsp_valid", 512'(bus.rsp_valid), 512'(exp_rv));
        check("addr_rsp_ready", 512'(bus.addr_rsp_ready), 512'(bus.rsp_ready[m_sel]));
        check("rsp_info", 512'(bus.rsp_info), 512'(bus.addr_rsp_info[TAG_W-1:SEL_BITS]));
        check("rsp_data", bus.rsp_data, bus.addr_rsp_data);
        m_deliver = bus.addr_rsp_valid && bus.rsp_ready[m_sel];
        last_win  = obs_winner();
        if (last_win >= 0) obs_grants.push_back(last_win);
        if (bus.addr_req_valid && bus.addr_req_ready) obs_tags.push_back(int'(bus.addr_req_info[SEL_BITS-1:0]));
    endtask

    // Advance the model across the rising edge with the inputs still stable.
    task automatic cycle_end();
        au_t e;
        @(posedge clk);
        cyc++;
        if (m_slot_v && bus.addr_req_ready) begin
            e.tag = m_slot_t;
            e.d   = m_slot_d;
            e.due = cyc + ((rsp_lat < 0) ? int'($urandom_range(0, 4)) : rsp_lat);
            au_q.push_back(e);
        end
        if (m_deliver) begin
            au_q.delete(0);
            if (rsp_budget > 0) rsp_budget--;
        end
        if (m_grant) begin
            m_slot_v = 1'b1;
            m_slot_d = bus.req_data[m_win*REQ_DATAW +: REQ_DATAW];
            m_slot_t = {bus.req_info[m_win*REQ_INFOW +: REQ_INFOW], SEL_BITS'(m_win)};
            m_ptr    = (m_win + 1) % NUM_REQS;
        end else if (bus.addr_req_ready) begin
            m_slot_v = 1'b0;
        end
        m_cnt = m_cnt + (m_grant ? 1 : 0) - (m_deliver ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            cycle_end();
        end
    endtask

    task automatic drain();
        en_mask      = '0;
        rsp_budget   = -1;
        rready_force = -1;
        p_rready     = 100;
        p_aready     = 100;
        rsp_lat      = 0;
        for (int n = 0; n < 60 && (m_cnt != 0 || m_slot_v); n++) run(1);
        cycle_begin();
        check("drain_pending", 512'(bus.pending_count), 512'(0));
        cycle_end();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ng;
        reset              = 1'b1;
        bus.req_valid      = '1;
        bus.req_data       = '0;
        bus.req_info       = '0;
        bus.addr_req_ready = 1'b1;
        bus.addr_rsp_valid = 1'b0;
        bus.addr_rsp_data  = '0;
        bus.addr_rsp_info  = '0;
        bus.rsp_ready      = '1;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_req_ready", 512'(bus.req_ready), 512'(0));
        check("reset_addr_req_valid", 512'(bus.addr_req_valid), 512'(0));
        check("reset_pending", 512'(bus.pending_count), 512'(0));
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;

        // Saturated round robin, responses three cycles after acceptance.
        obs_grants.delete();
        obs_tags.delete();
        en_mask = '1; p_valid = 100; p_aready = 100; p_rready = 100; rsp_lat = 3;
        run(12);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant_order", 512'(obs_grants[k]), 512'(k % NUM_REQS));
            check("rr_tag_order", 512'(obs_tags[k]), 512'(k % NUM_REQS));
        end
        drain();

        // Lone requester 2 with the pointer already past it.
        en_mask = 4'b0100;
        run(1);
        cycle_begin();
        check("wrap_grant_2", 512'(last_win), 512'(2));
        cycle_end();
        en_mask = '1;
        cycle_begin();
        check("ptr_after_wrap", 512'(last_win), 512'(3));
        cycle_end();
        drain();

        // Credit exhaustion and release of a single response.
        rsp_budget = 0; rsp_lat = 1; en_mask = '1; p_valid = 100;
        ng = 0;
        for (int n = 0; n < 8; n++) begin
            cycle_begin();
            if (last_win >= 0) ng++;
            cycle_end();
        end
        check("credit_grant_count", 512'(ng), 512'(MAX_PENDING));
        cycle_begin();
        check("credit_block", 512'(bus.req_ready), 512'(0));
        check("credit_full", 512'(bus.pending_count), 512'(MAX_PENDING));
        cycle_end();
        rsp_budget = 1;
        cycle_begin();
        check("credit_rsp_out", 512'(bus.rsp_valid != 0), 512'(1));
        check("credit_same_cycle", 512'(bus.req_ready), 512'(0));
        cycle_end();
        cycle_begin();
        check("credit_next_cycle", 512'(bus.req_ready != 0), 512'(1));
        cycle_end();
        cycle_begin();
        check("credit_refull", 512'(bus.req_ready), 512'(0));
        cycle_end();
        drain();

        // Slot held by a stalled address unit.
        en_mask = '1; p_aready = 0;
        cycle_begin();
        check("hold_first_grant", 512'(last_win >= 0), 512'(1));
        cycle_end();
        for (int n = 0; n < 5; n++) begin
            cycle_begin();
            check("hold_data", 512'(bus.addr_req_data), 512'(m_slot_d));
            check("hold_info", 512'(bus.addr_req_info), 512'(m_slot_t));
            check("hold_no_ready", 512'(bus.req_ready), 512'(0));
            check("hold_pending", 512'(bus.pending_count), 512'(1));
            cycle_end();
        end
        drain();

        // Response to requester 1 back-pressured for two cycles.
        en_mask = 4'b0010; rsp_lat = 1; rready_force = 4'b1101;
        cycle_begin();
        check("bp_grant_1", 512'(last_win), 512'(1));
        cycle_end();
        en_mask = '0;
        ng = 0;
        for (int n = 0; n < 10 && ng == 0; n++) begin
            cycle_begin();
            if (bus.addr_rsp_valid) ng = 1;
            else cycle_end();
        end
        check("bp_rsp_seen", 512'(ng), 512'(1));
        for (int n = 0; n < 2; n++) begin
            if (n > 0) cycle_begin();
            check("bp_rsp_valid", 512'(bus.rsp_valid), 512'(4'b0010));
            check("bp_rsp_ready", 512'(bus.addr_rsp_ready), 512'(0));
            check("bp_pending", 512'(bus.pending_count), 512'(1));
            cycle_end();
        end
        rready_force = 4'b1111;
        cycle_begin();
        check("bp_fire_valid", 512'(bus.rsp_valid), 512'(4'b0010));
        check("bp_fire_ready", 512'(bus.addr_rsp_ready), 512'(1));
        cycle_end();
        cycle_begin();
        check("bp_pending_after", 512'(bus.pending_count), 512'(0));
        cycle_end();
        drain();

        // Reset while three requests are in flight and the slot is occupied.
        rsp_budget = 0;
        en_mask = 4'b0100; run(1);
        en_mask = 4'b0010; run(1);
        en_mask = 4'b0100; run(1);
        en_mask = '0; p_aready = 0;
        cycle_begin();
        check("pre_rst_pending", 512'(bus.pending_count), 512'(3));
        check("pre_rst_slot", 512'(bus.addr_req_valid), 512'(1));
        cycle_end();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '1;
        #1;
        check("mid_rst_req_ready", 512'(bus.req_ready), 512'(0));
        check("mid_rst_addr_req_valid", 512'(bus.addr_req_valid), 512'(0));
        check("mid_rst_pending", 512'(bus.pending_count), 512'(0));
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        rsp_budget = -1; p_aready = 100; en_mask = '1;
        cycle_begin();
        check("rst_ptr_zero", 512'(last_win), 512'(0));
        cycle_end();
        drain();

        // Random traffic.
        en_mask = '1; rsp_lat = -1; rready_force = -1;
        p_valid = 60; p_aready = 70; p_rready = 70;
        run(1500);
        p_valid = 95; p_aready = 40; p_rready = 50;
        run(1000);
        p_valid = 30; p_aready = 90; p_rready = 90;
        run(500);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
